id_exe_stage: RTL

- Decode-to-execute boundary of the pipelined CPU; sits directly downstream of the forwarding unit and consumes its 2-bit FWDA/FWDB selects.
- Resolves each source operand from the register file or a bypass path.
- Detects load-use hazards that bypassing cannot cover, then raises stall and inserts a bubble.
- Registers decoded control and operands into the EXE stage; supports interrupt/exception flush and keeps a stall-cycle counter.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/operand_mux4.sv | 20 ++
 rtl/id_exe_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants, forwarding select encoding and EXE control bundle.
package cpu_pkg;

    localparam int DW_DEF  = 32;
    localparam int ACW_DEF = 4;

    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,
        FWD_EXE     = 2'b01,
        FWD_MEM_ALU = 2'b10,
        FWD_MEM_MDO = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic valid;
        logic wreg;
        logic m2reg;
        logic wmem;
        logic jal;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/operand_mux4.sv
// operand_mux4: selects one source operand from the register file or a bypass path.
module operand_mux4
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    output logic [DW-1:0] y
);

    always_comb
        y = sel == FWD_MEM_MDO ? d3 :
            sel == FWD_MEM_ALU ? d2 :
            sel == FWD_EXE     ? d1 : d0;

endmodule

// File: rtl/id_exe_stage.sv
// id_exe_stage: operand bypass, load-use stall detection and the ID/EXE pipeline register.
module id_exe_stage
    import cpu_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int ACW   = ACW_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             id_valid,
    input  logic             flush,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [1:0]       fwda,
    input  logic [1:0]       fwdb,
    input  logic [DW-1:0]    qa,
    input  logic [DW-1:0]    qb,
    input  logic [DW-1:0]    exe_alu,
    input  logic [DW-1:0]    mem_alu,
    input  logic [DW-1:0]    mem_mdo,
    input  logic [4:0]       exe_rn,
    input  logic             exe_wreg,
    input  logic             exe_m2reg,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             id_wmem,
    input  logic             id_aluimm,
    input  logic             id_shift,
    input  logic             id_jal,
    input  logic [ACW-1:0]   id_aluc,
    input  logic [4:0]       id_rn,
    input  logic [DW-1:0]    id_imm,
    input  logic [DW-1:0]    id_pc4,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_wreg,
    output logic             ex_m2reg,
    output logic             ex_wmem,
    output logic             ex_aluimm,
    output logic             ex_shift,
    output logic             ex_jal,
    output logic [ACW-1:0]   ex_aluc,
    output logic [4:0]       ex_rn,
    output logic [DW-1:0]    ex_a,
    output logic [DW-1:0]    ex_b,
    output logic [DW-1:0]    ex_imm,
    output logic [DW-1:0]    ex_pc4,
    output logic [CNT_W-1:0] stall_cnt
);

    logic          lu;
    logic          bubble;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    ctrl_t         id_ctrl;
    ctrl_t         ex_ctrl;

    operand_mux4 #(.DW(DW)) u_mux_a (
        .sel(fwda), .d0(qa), .d1(exe_alu), .d2(mem_alu), .d3(mem_mdo), .y(op_a)
    );

    operand_mux4 #(.DW(DW)) u_mux_b (
        .sel(fwdb), .d0(qb), .d1(exe_alu), .d2(mem_alu), .d3(mem_mdo), .y(op_b)
    );

    // A load in EXE cannot be bypassed to ID until it reaches MEM; r0 is never a real producer.
    assign lu = id_valid & exe_wreg & exe_m2reg & (|exe_rn) &
                ((use_rs & (exe_rn == rs)) | (use_rt & (exe_rn == rt)));
    assign stall  = lu & ~flush;
    assign bubble = flush | lu;

    assign id_ctrl = id_valid ? ctrl_t'{valid: 1'b1, wreg: id_wreg, m2reg: id_m2reg,
                                        wmem: id_wmem, jal: id_jal} : BUBBLE_CTRL;

    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            ex_ctrl   <= BUBBLE_CTRL;
            ex_aluimm <= 1'b0;
            ex_shift  <= 1'b0;
            ex_aluc   <= '0;
            ex_rn     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
            ex_pc4    <= '0;
        end else begin
            ex_ctrl   <= bubble ? BUBBLE_CTRL : id_ctrl;
            ex_aluimm <= ~bubble & id_aluimm;
            ex_shift  <= ~bubble & id_shift;
            ex_aluc   <= bubble ? '0 : id_aluc;
            ex_rn     <= bubble ? '0 : id_rn;
            ex_a      <= bubble ? '0 : op_a;
            ex_b      <= bubble ? '0 : op_b;
            ex_imm    <= bubble ? '0 : id_imm;
            ex_pc4    <= bubble ? '0 : id_pc4;
        end

    always_ff @(posedge clk or negedge clrn)
        if (!clrn)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + CNT_W'(stall & ~(&stall_cnt));

    assign ex_valid = ex_ctrl.valid;
    assign ex_wreg  = ex_ctrl.wreg;
    assign ex_m2reg = ex_ctrl.m2reg;
    assign ex_wmem  = ex_ctrl.wmem;
    assign ex_jal   = ex_ctrl.jal;

endmodule
